// File: rtl/gpu_fifo_pkg.sv
// Shared definitions for the GPU command/data FIFO: default geometry and the
// occupancy-counter width helper.
package gpu_fifo_pkg;

  localparam int GPU_FIFO_WIDTH = 32;
  localparam int GPU_FIFO_DEPTH = 16;

  // Occupancy needs one more bit than the pointers so that DEPTH itself is representable.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/gpu_fifo_sync_if.sv
// Port bundle between the CPU-side command port (master) and the FIFO (slave).
// The hwm signal exists only when GPU_FIFO_HWM_EN is defined.
interface gpu_fifo_sync_if
  import gpu_fifo_pkg::*;
#(
  parameter int WIDTH = GPU_FIFO_WIDTH,
  parameter int DEPTH = GPU_FIFO_DEPTH
);
  localparam int CW = fifo_cw(DEPTH);

  // we/re are single-cycle requests sampled on every rising edge; acceptance is
  // reported back only through count/full/empty and the sticky err_ovf/err_udf flags.
  logic             clr;
  logic             we;
  logic [WIDTH-1:0] data_in;
  logic             re;
  logic             err_clr;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             err_ovf;
  logic             err_udf;
`ifdef GPU_FIFO_HWM_EN
  logic [CW-1:0]    hwm;

  modport master (output clr, we, data_in, re, err_clr,
                  input  data_out, full, empty, almost_full, almost_empty,
                         count, err_ovf, err_udf, hwm);
  modport slave  (input  clr, we, data_in, re, err_clr,
                  output data_out, full, empty, almost_full, almost_empty,
                         count, err_ovf, err_udf, hwm);
`else
  modport master (output clr, we, data_in, re, err_clr,
                  input  data_out, full, empty, almost_full, almost_empty,
                         count, err_ovf, err_udf);
  modport slave  (input  clr, we, data_in, re, err_clr,
                  output data_out, full, empty, almost_full, almost_empty,
                         count, err_ovf, err_udf);
`endif

endinterface

// File: rtl/gpu_fifo_mem.sv
// WIDTH x DEPTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so the array maps onto distributed RAM.
module gpu_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gpu_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with thresholds and sticky error flags.
// Define GPU_FIFO_HWM_EN to add the hwm (high-water-mark) output.
module gpu_fifo_sync
  import gpu_fifo_pkg::*;
#(
  parameter int WIDTH    = GPU_FIFO_WIDTH,
  parameter int DEPTH    = GPU_FIFO_DEPTH,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic            clk,
  input  logic            rst,
  gpu_fifo_sync_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cw(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("gpu_fifo_sync: WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gpu_fifo_sync: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("gpu_fifo_sync: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("gpu_fifo_sync: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_next;
  logic             ovf_q;
  logic             udf_q;
  logic             full_w;
  logic             empty_w;
  logic             wacc;
  logic             racc;
  logic             set_ovf;
  logic             set_udf;
  logic [WIDTH-1:0] rdata;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A flush swallows any concurrent request, including its error side effects.
  always_comb begin
    wacc       = !bus.clr && bus.we && (!full_w || bus.re);
    racc       = !bus.clr && bus.re && !empty_w;
    set_ovf    = !bus.clr && bus.we && full_w && !bus.re;
    set_udf    = !bus.clr && bus.re && empty_w;
    count_next = bus.clr ? '0 : count_q + CW'(wacc) - CW'(racc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (bus.clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wacc) wr_ptr <= wr_ptr + 1'b1;
        if (racc) rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_next;
      // A fresh error in the same cycle as err_clr keeps the flag set.
      if (set_ovf)          ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (set_udf)          udf_q <= 1'b1;
      else if (bus.err_clr) udf_q <= 1'b0;
    end
  end

  gpu_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wacc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign bus.data_out     = empty_w ? '0 : rdata;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.err_ovf      = ovf_q;
  assign bus.err_udf      = udf_q;

`ifdef GPU_FIFO_HWM_EN
  logic [CW-1:0] hwm_q;

  always_ff @(posedge clk) begin
    if (rst || bus.clr || bus.err_clr) hwm_q <= '0;
    else if (count_next > hwm_q)       hwm_q <= count_next;
  end

  assign bus.hwm = hwm_q;
`endif

endmodule
